uart_baud_gen: RTL and testbench

- Free-running baud-rate tick generator for the UART receiver/transmitter.
- Divides the system clock to produce a one-cycle enable pulse at 16x the baud rate.
- The RX oversampler and the TX bit timer consume this 16x enable; it is the only timing source in the UART datapath.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 52 +++++
 tb/tb_uart_baud_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration helpers used by the baud generator, RX and TX.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ  = 125_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE = 115_200;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < 64'(v)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x baud enable: a one-cycle registered pulse every DIV system clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  logic CLK,
  input  logic RST,
  output logic BAUD_X16_EN
);

  // Divider rounded to nearest, halves up.
  localparam int unsigned DIV   = (CLK_FREQ + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int unsigned CNT_W = (clog2(DIV) > 1) ? clog2(DIV) : 1;

  generate
    if (DIV < 1) begin : g_bad_div
      $fatal(1, "uart_baud_gen: CLK_FREQ too low for BAUD_RATE, divider is zero");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             en_q;
  logic             en_nxt;

  // Wrap at DIV-1 and fire the enable on the same edge.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    en_nxt  = 1'b0;
    if (cnt == CNT_MAX) begin
      cnt_nxt = '0;
      en_nxt  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      en_q <= en_nxt;
    end
  end

  assign BAUD_X16_EN = en_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench: expected pulse edge indices are queued by stimulus and consumed by a negedge monitor.
module tb_uart_baud_gen;

  logic       clk;
  logic [4:0] rst;
  logic [4:0] en;

  int nvec;
  int nerr;
  int sel;
  int ecnt;
  bit win;
  int exp_q[$];

  // DIV = 6, 13, 10, 1, 68
  uart_baud_gen #(.CLK_FREQ(1000), .BAUD_RATE(10)) u_div6 (
    .CLK(clk), .RST(rst[0]), .BAUD_X16_EN(en[0]));
  uart_baud_gen #(.CLK_FREQ(1000), .BAUD_RATE(5)) u_div13 (
    .CLK(clk), .RST(rst[1]), .BAUD_X16_EN(en[1]));
  uart_baud_gen #(.CLK_FREQ(1000), .BAUD_RATE(6)) u_div10 (
    .CLK(clk), .RST(rst[2]), .BAUD_X16_EN(en[2]));
  uart_baud_gen #(.CLK_FREQ(160), .BAUD_RATE(10)) u_div1 (
    .CLK(clk), .RST(rst[3]), .BAUD_X16_EN(en[3]));
  uart_baud_gen #(.CLK_FREQ(125_000_000), .BAUD_RATE(115_200)) u_div68 (
    .CLK(clk), .RST(rst[4]), .BAUD_X16_EN(en[4]));

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Rising edges seen by the selected instance since its reset release.
  always @(posedge clk) begin
    if (rst[sel]) ecnt = ecnt + 1;
    else          ecnt = 0;
  end

  // Monitor: every high sample must match the next queued edge; a queued edge with no pulse is missing.
  always @(negedge clk) begin
    int e;
    if (win) begin
      if (en[sel]) begin
        nvec = nvec + 1;
        if (exp_q.size() == 0) begin
          nerr = nerr + 1;
          $display("FAIL unexpected_pulse inst=%0d: pulse at edge %0d, required no pulse", sel, ecnt);
        end else begin
          e = exp_q.pop_front();
          if (e != ecnt) begin
            nerr = nerr + 1;
            $display("FAIL pulse_edge inst=%0d: pulse at edge %0d, required edge %0d", sel, ecnt, e);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0] == ecnt) begin
        nvec = nvec + 1;
        nerr = nerr + 1;
        e = exp_q.pop_front();
        $display("FAIL missing_pulse inst=%0d: no pulse at edge %0d, required pulse", sel, e);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nvec = nvec + 1;
    if (act != exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Release instance i (currently in reset) and expect n pulses spaced div edges apart.
  task automatic run_pulses(input int i, input int div, input int n);
    @(posedge clk);
    #2;
    sel  = i;
    ecnt = 0;
    exp_q.delete();
    for (int k = 1; k <= n; k++) exp_q.push_back(k * div);
    win    = 1'b1;
    rst[i] = 1'b1;
    repeat (n * div + div - 1) @(posedge clk);
    @(negedge clk);
    #1;
    win = 1'b0;
    check($sformatf("pulses_outstanding_inst%0d", i), exp_q.size(), 0);
    rst[i] = 1'b0;
    #1;
    check($sformatf("en_after_reset_inst%0d", i), int'(en[i]), 0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    sel  = 0;
    ecnt = 0;
    win  = 1'b0;
    rst  = 5'b00000;

    #1;
    check("all_en_in_reset", int'(en), 0);

    // Start-up: held in reset for 10 cycles, then 10 pulses of period 6.
    repeat (10) begin
      @(posedge clk);
      #2;
      check("en_held_in_reset", int'(en[0]), 0);
    end
    check("cnt_held_in_reset", int'(u_div6.cnt), 0);
    run_pulses(0, 6, 10);

    // Async reset three edges into a period.
    @(posedge clk);
    #2;
    rst[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("cnt_mid_period", int'(u_div6.cnt), 3);
    rst[0] = 1'b0;
    #1;
    check("en_async_mid", int'(en[0]), 0);
    check("cnt_async_mid", int'(u_div6.cnt), 0);
    repeat (2) @(posedge clk);
    run_pulses(0, 6, 3);

    // Async reset while the pulse is high.
    @(posedge clk);
    #2;
    rst[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("en_at_pulse", int'(en[0]), 1);
    rst[0] = 1'b0;
    #1;
    check("en_async_on_pulse", int'(en[0]), 0);
    check("cnt_async_on_pulse", int'(u_div6.cnt), 0);
    repeat (2) @(posedge clk);
    run_pulses(0, 6, 3);

    // Rounding cases, DIV=1 continuous enable, and default configuration.
    run_pulses(1, 13, 10);
    run_pulses(2, 10, 10);
    run_pulses(3, 1, 20);
    run_pulses(4, 68, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
